// File: rtl/mem_arb_pkg.sv
// Shared constants for the CPU/DMA memory arbiter: FSM encoding, owner
// encoding and the legal read-latency range.
package mem_arb_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_ISSUE = 2'd1;
  localparam state_t S_WAIT  = 2'd2;
  localparam state_t S_ACK   = 2'd3;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

  localparam int unsigned MEM_LAT_MIN = 1;
  localparam int unsigned MEM_LAT_MAX = 4;
  localparam int unsigned CNT_W       = 2;

  // Out-of-range latencies are clamped so the counter can never wrap.
  function automatic logic [CNT_W-1:0] lat_load(input int unsigned lat);
    int unsigned l;
    l = (lat < MEM_LAT_MIN) ? MEM_LAT_MIN :
        (lat > MEM_LAT_MAX) ? MEM_LAT_MAX : lat;
    return CNT_W'(l - 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-input round-robin picker. On a tie the side not granted last wins;
// last_grant moves only on the ACK strobe.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  input  logic       upd_own_i,
  output logic       valid_o,
  output logic       gnt_o
);

  logic last_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     last_q <= OWN_DMA;
    else if (upd_i) last_q <= upd_own_i;
  end

  always_comb begin
    valid_o = |req_i;
    unique case (req_i)
      2'b01:   gnt_o = OWN_CPU;
      2'b10:   gnt_o = OWN_DMA;
      2'b11:   gnt_o = ~last_q;
      default: gnt_o = OWN_CPU;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the unified memory between the CPU and a DMA/debug port. Each
// access runs IDLE -> ISSUE -> WAIT(MEM_LAT) -> ACK; the CPU stalls until ack.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               owner_q, we_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q, cpu_rdata_q, dma_rdata_q;
  logic               arb_valid, arb_gnt;
  logic               latch, capture;

  rr_arb2 u_rr (
    .clk       (clk),
    .reset     (reset),
    .req_i     ({dma_req, cpu_req}),
    .upd_i     (state_q == S_ACK),
    .upd_own_i (owner_q),
    .valid_o   (arb_valid),
    .gnt_o     (arb_gnt)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE:  if (arb_valid) state_d = S_ISSUE;
      S_ISSUE: begin
        cnt_d   = lat_load(MEM_LAT);
        state_d = S_WAIT;
      end
      S_WAIT:  if (cnt_q == '0) state_d = S_ACK;
               else             cnt_d   = cnt_q - CNT_W'(1);
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request inputs are only sampled here; later changes cannot leak in.
  assign latch   = (state_q == S_IDLE) && arb_valid;
  assign capture = (state_q == S_WAIT) && (cnt_q == '0) && !we_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q <= OWN_CPU;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (latch) begin
      owner_q <= arb_gnt;
      we_q    <= (arb_gnt == OWN_DMA) ? dma_we    : cpu_we;
      addr_q  <= (arb_gnt == OWN_DMA) ? dma_addr  : cpu_addr;
      wdata_q <= (arb_gnt == OWN_DMA) ? dma_wdata : cpu_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else if (capture) begin
      if (owner_q == OWN_DMA) dma_rdata_q <= mem_rdata;
      else                    cpu_rdata_q <= mem_rdata;
    end
  end

  assign mem_en    = (state_q == S_ISSUE);
  assign mem_we    = mem_en & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_ack   = (state_q == S_ACK) && (owner_q == OWN_CPU);
  assign dma_ack   = (state_q == S_ACK) && (owner_q == OWN_DMA);
  assign cpu_rdata = cpu_rdata_q;
  assign dma_rdata = dma_rdata_q;
  // Combinational so the controller freezes in the very cycle req rises.
  assign cpu_stall = cpu_req & ~cpu_ack;
  assign busy      = (state_q != S_IDLE);
  assign owner     = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random two-port traffic,
// checked against a transaction-timing model and a word memory.
module tb_mem_arbiter;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  req, we;
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        cpu_ack, dma_ack, cpu_stall, mem_en, mem_we, busy, owner;

  int n_run = 0, n_fail = 0;
  int cyc = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(req[0]), .cpu_we(we[0]), .cpu_addr(addr[0]), .cpu_wdata(wdata[0]),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
    .dma_req(req[1]), .dma_we(we[1]), .dma_addr(addr[1]), .dma_wdata(wdata[1]),
    .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- memory + reference model ----------------
  logic [31:0] mem [64];
  bit          mem_init = 0;
  int          rd_cyc = -1;
  logic [31:0] rd_val;
  logic [1:0]  ack_seen;

  bit          m_active;
  logic        m_own, m_last, m_we;
  logic [31:0] m_addr, m_wdata, m_exp_rd;
  logic [31:0] m_rd [2];
  int          m_issue, m_ack;

  always @(posedge clk) begin
    #1;
    mem_rdata = (cyc == rd_cyc) ? rd_val : $urandom;
  end

  always @(negedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] = i * 32'h01010101;
      mem[4] = 32'hE3A01005;
      mem_init = 1;
    end
    if (!reset) begin
      m_active = 0; m_last = 1'b1; m_rd[0] = '0; m_rd[1] = '0;
      rd_cyc = -1; ack_seen = '0;
      chk("rst_busy", busy, 0);
      chk("rst_mem_en", {mem_en, mem_we}, 0);
      chk("rst_acks", {cpu_ack, dma_ack}, 0);
      chk("rst_owner", owner, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_rdata", cpu_rdata | dma_rdata, 0);
    end else begin
      chk("cpu_stall", cpu_stall, req[0] & ~cpu_ack);
      chk("busy", busy, m_active);
      if (!m_active && req != 2'b00) begin
        // Tie goes to whoever was not granted last; else the lone requester.
        m_own   = (req == 2'b11) ? ~m_last : req[1];
        m_we    = we[m_own];
        m_addr  = addr[m_own];
        m_wdata = wdata[m_own];
        m_issue = cyc + 1;
        m_ack   = cyc + 2 + LAT;
        m_active = 1;
      end
      chk("mem_en", mem_en, m_active && cyc == m_issue);
      if (m_active && cyc == m_issue) begin
        m_exp_rd = mem[m_addr[7:2]];
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_we", mem_we, m_we);
        chk("owner_issue", owner, m_own);
        if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
      end
      if (mem_en) begin
        if (mem_we) mem[mem_addr[7:2]] = mem_wdata;
        else begin
          rd_val = mem[mem_addr[7:2]];
          rd_cyc = cyc + LAT;
        end
      end
      chk("cpu_ack", cpu_ack, m_active && cyc == m_ack && m_own == 1'b0);
      chk("dma_ack", dma_ack, m_active && cyc == m_ack && m_own == 1'b1);
      if (m_active && cyc == m_ack) begin
        if (!m_we) m_rd[m_own] = m_exp_rd;
        chk("owner_ack", owner, m_own);
        m_last = m_own;
        m_active = 0;
      end
      chk("cpu_rdata", cpu_rdata, m_rd[0]);
      chk("dma_rdata", dma_rdata, m_rd[1]);
      ack_seen = {dma_ack, cpu_ack};
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_req(input int p, input logic w, input logic [31:0] a, input logic [31:0] d);
    req[p] = 1'b1; we[p] = w; addr[p] = a; wdata[p] = d;
  endtask

  task automatic rnd_req(input int p);
    set_req(p, 1'($urandom_range(0, 1)), {24'd0, 6'($urandom_range(0, 63)), 2'b00}, $urandom);
  endtask

  task automatic wait_ack(input int p, output int at, output logic [31:0] rd);
    at = -1; rd = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ((p == 0) ? cpu_ack : dma_ack) begin
        at = cyc; rd = (p == 0) ? cpu_rdata : dma_rdata;
        break;
      end
    end
    chk($sformatf("ack_timeout_p%0d", p), at < 0, 0);
  endtask

  task automatic wait_en();
    int seen = 0;
    for (int i = 0; i < 40 && seen == 0; i++) begin
      @(negedge clk);
      if (mem_en) seen = 1;
    end
    chk("mem_en_timeout", seen, 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b0; req = '0;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  initial begin
    int n0, at, at2, seen;
    logic [31:0] rd;
    req = '0; we = '0;
    addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // CPU read of 0x10
    @(posedge clk); #1;
    n0 = cyc; set_req(0, 1'b0, 32'h10, 32'h0);
    wait_ack(0, at, rd);
    chk("cpu_rd_lat", at - n0, LAT + 2);
    chk("cpu_rd_data", rd, 32'hE3A01005);
    @(posedge clk); #1 req[0] = 1'b0;

    // DMA write 0x80 then read it back
    @(posedge clk); #1;
    n0 = cyc; set_req(1, 1'b1, 32'h80, 32'hDEADBEEF);
    wait_ack(1, at, rd);
    chk("dma_wr_lat", at - n0, LAT + 2);
    @(posedge clk); #1 set_req(1, 1'b0, 32'h80, 32'h0);
    wait_ack(1, at, rd);
    chk("dma_rd_back", rd, 32'hDEADBEEF);
    @(posedge clk); #1 req[1] = 1'b0;

    // Simultaneous requests straight after reset: CPU first
    do_reset();
    set_req(0, 1'b0, 32'h20, 32'h0);
    set_req(1, 1'b0, 32'h24, 32'h0);
    wait_ack(0, at, rd);
    chk("tie_owner_first", owner, 0);
    @(posedge clk); #1 req[0] = 1'b0;
    wait_ack(1, at2, rd);
    chk("tie_gap", at2 - at, LAT + 3);
    @(posedge clk); #1 req[1] = 1'b0;

    // Both held: six alternating grants
    do_reset();
    rnd_req(0); rnd_req(1);
    for (int i = 0; i < 6; i++) begin
      seen = 0;
      for (int j = 0; j < 40 && seen == 0; j++) begin
        @(negedge clk);
        if (cpu_ack || dma_ack) seen = 1;
      end
      chk($sformatf("alt_seen%0d", i), seen, 1);
      chk($sformatf("alt_owner%0d", i), owner, i % 2);
      chk($sformatf("alt_dma_ack%0d", i), dma_ack, i % 2);
      @(posedge clk); #1;
      if (i == 5) req = '0;
      else        rnd_req(i % 2);
    end

    // CPU drops req during WAIT
    @(posedge clk); #1;
    n0 = cyc; set_req(0, 1'b0, 32'h30, 32'h0);
    wait_en();
    @(posedge clk); #1 req[0] = 1'b0;
    wait_ack(0, at, rd);
    chk("drop_lat", at - n0, LAT + 2);
    @(negedge clk);
    chk("drop_idle", busy, 0);

    // Reset in the middle of WAIT
    @(posedge clk); #1;
    set_req(0, 1'b0, 32'h40, 32'h0);
    wait_en();
    @(posedge clk); #3 reset = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_ack", {cpu_ack, dma_ack, mem_en}, 0);
    chk("midrst_addr", mem_addr, 0);
    req = '0;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    n0 = cyc; set_req(0, 1'b0, 32'h40, 32'h0);
    wait_ack(0, at, rd);
    chk("post_rst_lat", at - n0, LAT + 2);
    chk("post_rst_data", rd, 32'h10101010);
    @(posedge clk); #1 req[0] = 1'b0;

    // Random two-port traffic
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      for (int p = 0; p < 2; p++) begin
        if (req[p]) begin
          if (ack_seen[p]) begin
            if ($urandom_range(0, 3) != 0) rnd_req(p);
            else req[p] = 1'b0;
          end else if ($urandom_range(0, 7) == 0) begin
            addr[p]  = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
            wdata[p] = $urandom;
          end
        end else if ($urandom_range(0, 2) == 0) rnd_req(p);
      end
    end
    // Let any in-flight access drain, dropping each request once acked.
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      for (int p = 0; p < 2; p++) if (ack_seen[p]) req[p] = 1'b0;
    end
    req = '0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("final_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
